// File: rtl/dmem_arbiter_if.sv
// Purpose : one master-side data-memory access channel into dmem_arbiter.
// Signals : req/we/addr/wdata driven by the master; gnt/rvalid/rdata driven
//           by the arbiter. addr[10] selects the IO register, else RAM.
interface dmem_arbiter_if;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose : round-robin arbiter sharing one synchronous data RAM and one
//           memory-mapped output register between two masters (0 = CPU,
//           1 = loader/debug). One transaction in flight at a time.
// Ports   : clock, reset (async, active-high)
//           m0, m1          : master channels (dmem_arbiter_if.slave)
//           ram_we/addr/wdata, ram_rdata : synchronous RAM port
//           io_ena, io_dout : IO register write strobe and contents
module dmem_arbiter #(
  parameter int unsigned RAM_AW = 10,
  parameter int unsigned IO_W   = 21
) (
  input  logic              clock,
  input  logic              reset,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              io_ena,
  output logic [IO_W-1:0]   io_dout
);

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;     // master granted most recently
  logic                sel_q, sel_d;       // master owning the current transaction
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                ram_we_q, ram_we_d;
  logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                io_ena_q, io_ena_d;
  logic [IO_W-1:0]     io_dout_q, io_dout_d;
  logic                win;
  logic [DATA_W-1:0]   rd_mux;

  // Round-robin pick: a lone requester wins, a tie goes to the other master.
  always_comb begin
    win = 1'b0;
    if (m0.req && m1.req) win = ~last_q;
    else                  win = m1.req;
  end

  // Read return source, chosen by the latched address space.
  always_comb begin
    rd_mux = ram_rdata;
    if (addr_q[10]) rd_mux = DATA_W'(io_dout_q);
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    gnt_d       = 2'b00;
    rvalid_d    = 2'b00;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    io_ena_d    = 1'b0;
    io_dout_d   = io_dout_q;

    case (state_q)
      IDLE: begin
        if (m0.req || m1.req) begin
          sel_d   = win;
          last_d  = win;
          we_d    = win ? m1.we    : m0.we;
          addr_d  = win ? m1.addr  : m0.addr;
          wdata_d = win ? m1.wdata : m0.wdata;
          gnt_d[win] = 1'b1;
          // Present the access during ACCESS so RAM/IO strobes line up with it.
          ram_addr_d  = RAM_AW'(addr_d[9:0]);
          ram_wdata_d = wdata_d;
          ram_we_d    = we_d & ~addr_d[10];
          io_ena_d    = we_d & addr_d[10];
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          if (addr_q[10]) io_dout_d = wdata_q[IO_W-1:0];
          state_d = IDLE;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        rvalid_d[sel_q] = 1'b1;
        if (sel_q) rdata1_d = rd_mux;
        else       rdata0_d = rd_mux;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      io_ena_q    <= 1'b0;
      io_dout_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      io_ena_q    <= io_ena_d;
      io_dout_q   <= io_dout_d;
    end
  end

  assign m0.gnt    = gnt_q[0];
  assign m1.gnt    = gnt_q[1];
  assign m0.rvalid = rvalid_q[0];
  assign m1.rvalid = rvalid_q[1];
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign io_ena    = io_ena_q;
  assign io_dout   = io_dout_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table of single-master transactions, a
// read-data scoreboard, plus hand-written tie-arbitration and reset-abort runs.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        io_ena;
  logic [20:0] io_dout;

  dmem_arbiter_if m0_if ();
  dmem_arbiter_if m1_if ();

  dmem_arbiter #(.RAM_AW(10), .IO_W(21)) dut (
    .clock     (clk),
    .reset     (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .io_ena    (io_ena),
    .io_dout   (io_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model: read data valid one cycle after the address.
  logic [31:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          m;
    logic [31:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    int          m;
    logic        we;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;   // read data, or stored value after a write
  } vec_t;

  function automatic logic gnt_of(input int m);
    return (m == 1) ? m1_if.gnt : m0_if.gnt;
  endfunction

  function automatic logic rvalid_of(input int m);
    return (m == 1) ? m1_if.rvalid : m0_if.rvalid;
  endfunction

  function automatic logic [31:0] rdata_of(input int m);
    return (m == 1) ? m1_if.rdata : m0_if.rdata;
  endfunction

  task automatic drive(input int m, input logic r, input logic w,
                       input logic [10:0] a, input logic [31:0] d);
    if (m == 1) begin
      m1_if.req = r; m1_if.we = w; m1_if.addr = a; m1_if.wdata = d;
    end else begin
      m0_if.req = r; m0_if.we = w; m0_if.addr = a; m0_if.wdata = d;
    end
  endtask

  // Bounded wait for master m's grant; n = edges waited.
  task automatic wait_gnt(input int m, output int n);
    logic got;
    got = 1'b0;
    n = 0;
    while (!got && n < 8) begin
      @(posedge clk); #1;
      n++;
      got = gnt_of(m);
    end
  endtask

  // Read-data scoreboard: every rvalid must match the oldest pending read.
  always @(negedge clk) begin
    if (m0_if.rvalid || m1_if.rvalid) begin
      sb_t e;
      chk("rvalid_onehot", 32'(m0_if.rvalid & m1_if.rvalid), 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_rvalid", 32'(m1_if.rvalid), 32'(m0_if.rvalid) + 32'd2);
      end else begin
        e = sb_q.pop_front();
        chk("sb_master", 32'(m1_if.rvalid), 32'(e.m));
        chk("sb_rdata", m1_if.rvalid ? m1_if.rdata : m0_if.rdata, e.data);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int n;
    drive(v.m, 1'b1, v.we, v.addr, v.wdata);
    wait_gnt(v.m, n);
    drive(v.m, 1'b0, 1'b0, 11'h0, 32'h0);
    chk("gnt_latency", 32'(n), 32'd1);
    chk("other_gnt", 32'(gnt_of(1 - v.m)), 32'd0);
    chk("acc_ram_we", 32'(ram_we), 32'(v.we & ~v.addr[10]));
    chk("acc_io_ena", 32'(io_ena), 32'(v.we & v.addr[10]));
    chk("acc_ram_addr", 32'(ram_addr), 32'(v.addr[9:0]));
    chk("acc_ram_wdata", ram_wdata, v.wdata);
    if (v.we) begin
      @(posedge clk); #1;
      chk("wr_gnt_pulse", 32'(gnt_of(v.m)), 32'd0);
      chk("wr_ram_we_off", 32'(ram_we), 32'd0);
      chk("wr_io_ena_off", 32'(io_ena), 32'd0);
      if (v.addr[10]) chk("wr_io_dout", 32'(io_dout), v.exp);
      else            chk("wr_mem", mem[v.addr[9:0]], v.exp);
    end else begin
      sb_q.push_back('{m: v.m, data: v.exp});
      @(posedge clk); #1;
      chk("rd_early_rvalid", 32'(rvalid_of(v.m)), 32'd0);
      @(posedge clk); #1;
      chk("rd_rvalid", 32'(rvalid_of(v.m)), 32'd1);
      chk("rd_other_rvalid", 32'(rvalid_of(1 - v.m)), 32'd0);
      @(posedge clk); #1;
      chk("rd_rvalid_pulse", 32'(rvalid_of(v.m)), 32'd0);
      chk("rd_rdata_hold", rdata_of(v.m), v.exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int gm[$];
    int gc[$];
    int n;

    vecs[0] = '{m: 0, we: 1'b1, addr: 11'h005, wdata: 32'hDEADBEEF, exp: 32'hDEADBEEF};
    vecs[1] = '{m: 1, we: 1'b0, addr: 11'h005, wdata: 32'h0,        exp: 32'hDEADBEEF};
    vecs[2] = '{m: 0, we: 1'b1, addr: 11'h400, wdata: 32'h12345678, exp: 32'h00145678};
    vecs[3] = '{m: 1, we: 1'b0, addr: 11'h7FF, wdata: 32'h0,        exp: 32'h00145678};
    vecs[4] = '{m: 1, we: 1'b1, addr: 11'h3FF, wdata: 32'hAAAA5555, exp: 32'hAAAA5555};
    vecs[5] = '{m: 0, we: 1'b0, addr: 11'h3FF, wdata: 32'h0,        exp: 32'hAAAA5555};
    vecs[6] = '{m: 0, we: 1'b1, addr: 11'h7FF, wdata: 32'hFFFFFFFF, exp: 32'h001FFFFF};
    vecs[7] = '{m: 0, we: 1'b0, addr: 11'h400, wdata: 32'h0,        exp: 32'h001FFFFF};
    vecs[8] = '{m: 1, we: 1'b0, addr: 11'h200, wdata: 32'h0,        exp: 32'h00000000};
    vecs[9] = '{m: 1, we: 1'b0, addr: 11'h020, wdata: 32'h0,        exp: 32'h11111111};

    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 11'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 11'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("rst_gnt", {30'd0, m1_if.gnt, m0_if.gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, m1_if.rvalid, m0_if.rvalid}, 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_io_ena", 32'(io_ena), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_rdata0", m0_if.rdata, 32'd0);
    chk("rst_rdata1", m1_if.rdata, 32'd0);
    chk("rst_io_dout", 32'(io_dout), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_gnt", {30'd0, m1_if.gnt, m0_if.gnt}, 32'd0);

    // Both masters request continuously: m0 wins the first tie, then alternate.
    drive(0, 1'b1, 1'b1, 11'h020, 32'h11111111);
    drive(1, 1'b1, 1'b1, 11'h021, 32'h22222222);
    for (int c = 1; c <= 20 && gm.size() < 4; c++) begin
      @(posedge clk); #1;
      chk("alt_gnt_onehot", 32'(m0_if.gnt & m1_if.gnt), 32'd0);
      if (m0_if.gnt) begin gm.push_back(0); gc.push_back(c); end
      else if (m1_if.gnt) begin gm.push_back(1); gc.push_back(c); end
    end
    drive(0, 1'b0, 1'b0, 11'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 11'h0, 32'h0);
    chk("alt_count", 32'(gm.size()), 32'd4);
    if (gc.size() > 0) chk("alt_first_cycle", 32'(gc[0]), 32'd1);
    for (int i = 0; i < gm.size(); i++) begin
      chk("alt_master", 32'(gm[i]), 32'(i % 2));
      if (i > 0) chk("alt_spacing", 32'(gc[i] - gc[i-1]), 32'd2);
    end
    @(posedge clk); #1;
    chk("alt_mem0", mem[11'h020 & 10'h3FF], 32'h11111111);
    chk("alt_mem1", mem[11'h021 & 10'h3FF], 32'h22222222);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset in ACCESS of an m0 RAM write: abort, nothing written.
    drive(0, 1'b1, 1'b1, 11'h010, 32'hCAFEF00D);
    wait_gnt(0, n);
    chk("abort_wr_gnt", 32'(n), 32'd1);
    #2 rst = 1'b1;
    drive(0, 1'b0, 1'b0, 11'h0, 32'h0);
    #1;
    chk("abort_wr_ram_we", 32'(ram_we), 32'd0);
    chk("abort_wr_gnt0", 32'(m0_if.gnt), 32'd0);
    chk("abort_wr_ram_addr", 32'(ram_addr), 32'd0);
    chk("abort_wr_ram_wdata", ram_wdata, 32'd0);
    chk("abort_wr_io_dout", 32'(io_dout), 32'd0);
    chk("abort_wr_rdata0", m0_if.rdata, 32'd0);
    chk("abort_wr_rdata1", m1_if.rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_wr_mem", mem[10'h010], 32'h0);

    // Reset in RDWAIT of an m1 read: no rvalid may follow.
    drive(1, 1'b1, 1'b0, 11'h005, 32'h0);
    wait_gnt(1, n);
    drive(1, 1'b0, 1'b0, 11'h0, 32'h0);
    chk("abort_rd_gnt", 32'(n), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_rd_rvalid_rst", 32'(m1_if.rvalid), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_rd_rvalid_post", 32'(m1_if.rvalid), 32'd0);
    end

    // Master re-requests after the abort and completes normally.
    run_vec('{m: 1, we: 1'b0, addr: 11'h005, wdata: 32'h0, exp: 32'hDEADBEEF});

    repeat (2) @(posedge clk); #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
